// File: rtl/tcm_arb_pkg.sv
// Shared types and defaults for the TCM port arbiter.
// The tracking FIFO stores the widest supported tag; the top level narrows it to TAG_W.
package tcm_arb_pkg;

  localparam int OUTSTANDING_DEF = 2;
  localparam int TAG_W_DEF       = 11;
  localparam int TAG_W_MAX       = 32;

  typedef enum logic [1:0] {
    SRC_I     = 2'd0,
    SRC_D     = 2'd1,
    SRC_LOCAL = 2'd2
  } arb_src_t;

  typedef struct packed {
    arb_src_t               src;
    logic [TAG_W_MAX-1:0]   tag;
    logic                   kill;
  } arb_entry_t;

endpackage

// File: rtl/tcm_arb_fifo.sv
// In-order tracking FIFO of issued transactions.
// It can mark every queued fetch entry (and one being pushed) as killed.
module tcm_arb_fifo
  import tcm_arb_pkg::*;
#(
  parameter int DEPTH = OUTSTANDING_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  arb_entry_t push_entry_i,
  input  logic       pop_i,
  input  logic       kill_ifetch_i,
  output arb_entry_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  arb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  arb_entry_t        entry_w;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    entry_w      = push_entry_i;
    entry_w.kill = push_entry_i.kill | (kill_ifetch_i & (push_entry_i.src == SRC_I));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      // Stale slots may also get marked; they are overwritten on their next push.
      if (kill_ifetch_i) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (mem_q[k].src == SRC_I) mem_q[k].kill <= 1'b1;
        end
      end
      if (push_ok) begin
        mem_q[wr_ptr_q] <= entry_w;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tcm_port_arbiter.sv
// Round-robin sharing of one single-port TCM between fetch and data ports.
// Responses come back in order and are steered by the tracking FIFO head.
module tcm_port_arbiter
  import tcm_arb_pkg::*;
#(
  parameter int OUTSTANDING = OUTSTANDING_DEF,
  parameter int TAG_W       = TAG_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mem_i_rd_i,
  input  logic [31:0]      mem_i_pc_i,
  input  logic             mem_i_flush_i,
  input  logic             mem_i_invalidate_i,
  output logic             mem_i_accept_o,
  output logic             mem_i_valid_o,
  output logic             mem_i_error_o,
  output logic [31:0]      mem_i_inst_o,
  input  logic [31:0]      mem_d_addr_i,
  input  logic [31:0]      mem_d_data_wr_i,
  input  logic             mem_d_rd_i,
  input  logic [3:0]       mem_d_wr_i,
  input  logic             mem_d_cacheable_i,
  input  logic [TAG_W-1:0] mem_d_req_tag_i,
  input  logic             mem_d_invalidate_i,
  input  logic             mem_d_writeback_i,
  input  logic             mem_d_flush_i,
  output logic             mem_d_accept_o,
  output logic             mem_d_ack_o,
  output logic             mem_d_error_o,
  output logic [31:0]      mem_d_data_rd_o,
  output logic [TAG_W-1:0] mem_d_resp_tag_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_wr_o,
  output logic             mem_rd_o,
  output logic [3:0]       mem_wr_o,
  input  logic             mem_accept_i,
  input  logic             mem_ack_i,
  input  logic             mem_error_i,
  input  logic [31:0]      mem_data_rd_i
);

  arb_src_t    rr_q, rr_d;
  arb_entry_t  head, push_entry;
  logic        fifo_full, fifo_empty, push, pop;
  logic        i_kill, i_req, d_op, d_mem, d_req, grant_i, grant_d, issue_ok;
  logic        i_acc, d_acc, head_killed;
  logic        i_valid_q, i_err_q, d_ack_q, d_err_q;
  logic [31:0] i_inst_q, d_data_q;
  logic [TAG_W-1:0] d_tag_q;
  logic        unused_ok;

  assign i_kill   = mem_i_flush_i | mem_i_invalidate_i;
  assign i_req    = mem_i_rd_i & ~i_kill;
  assign d_op     = mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;
  assign d_mem    = ~d_op & (mem_d_rd_i | (|mem_d_wr_i));
  assign d_req    = d_op | d_mem;
  assign grant_d  = d_req & (~i_req | (rr_q == SRC_I));
  assign grant_i  = i_req & ~grant_d;
  assign issue_ok = ~fifo_full & ~rst_i;

  always_comb begin
    mem_addr_o    = '0;
    mem_data_wr_o = '0;
    mem_rd_o      = 1'b0;
    mem_wr_o      = '0;
    if (issue_ok && grant_i) begin
      mem_addr_o = mem_i_pc_i;
      mem_rd_o   = 1'b1;
    end else if (issue_ok && grant_d && d_mem) begin
      mem_addr_o    = mem_d_addr_i;
      mem_data_wr_o = mem_d_data_wr_i;
      mem_wr_o      = mem_d_wr_i;
      mem_rd_o      = mem_d_rd_i & (mem_d_wr_i == 4'b0);
    end
  end

  // Cache ops never touch the TCM, so they do not wait for mem_accept_i.
  assign i_acc          = issue_ok & grant_i & mem_accept_i;
  assign d_acc          = issue_ok & grant_d & (d_op | mem_accept_i);
  assign mem_i_accept_o = i_acc;
  assign mem_d_accept_o = d_acc;
  assign push           = i_acc | d_acc;

  always_comb begin
    push_entry     = '0;
    push_entry.src = grant_i ? SRC_I : (d_op ? SRC_LOCAL : SRC_D);
    push_entry.tag = grant_i ? '0 : TAG_W_MAX'(mem_d_req_tag_i);
  end

  always_comb begin
    rr_d = rr_q;
    if (i_acc)      rr_d = SRC_I;
    else if (d_acc) rr_d = SRC_D;
  end

  assign pop         = ~fifo_empty & (mem_ack_i | (head.src == SRC_LOCAL));
  assign head_killed = head.kill | i_kill;

  tcm_arb_fifo #(.DEPTH(OUTSTANDING)) u_fifo (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .push_i        (push),
    .push_entry_i  (push_entry),
    .pop_i         (pop),
    .kill_ifetch_i (i_kill),
    .head_o        (head),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q      <= SRC_I;
      i_valid_q <= 1'b0;
      i_err_q   <= 1'b0;
      i_inst_q  <= '0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      d_data_q  <= '0;
      d_tag_q   <= '0;
    end else begin
      rr_q      <= rr_d;
      i_valid_q <= 1'b0;
      d_ack_q   <= 1'b0;
      if (pop) begin
        unique case (head.src)
          SRC_I: begin
            if (!head_killed) begin
              i_valid_q <= 1'b1;
              i_inst_q  <= mem_data_rd_i;
              i_err_q   <= mem_error_i;
            end
          end
          SRC_D: begin
            d_ack_q  <= 1'b1;
            d_data_q <= mem_data_rd_i;
            d_err_q  <= mem_error_i;
            d_tag_q  <= head.tag[TAG_W-1:0];
          end
          SRC_LOCAL: begin
            d_ack_q  <= 1'b1;
            d_data_q <= '0;
            d_err_q  <= 1'b0;
            d_tag_q  <= head.tag[TAG_W-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_i_valid_o    = i_valid_q;
  assign mem_i_error_o    = i_err_q;
  assign mem_i_inst_o     = i_inst_q;
  assign mem_d_ack_o      = d_ack_q;
  assign mem_d_error_o    = d_err_q;
  assign mem_d_data_rd_o  = d_data_q;
  assign mem_d_resp_tag_o = d_tag_q;

  assign unused_ok = ^{mem_d_cacheable_i, head.tag};

  // A downstream ack must belong to a downstream entry at the head.
  a_ack_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    !(mem_ack_i && fifo_empty));
  a_ack_local: assert property (@(posedge clk_i) disable iff (rst_i)
    !(mem_ack_i && !fifo_empty && (head.src == SRC_LOCAL)));

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Directed bench for tcm_port_arbiter with a small in-order TCM responder.
// Read data returned by the responder is the bitwise inverse of the address.
module tb_tcm_port_arbiter;
  import tcm_arb_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i;
  logic [31:0] mem_i_pc_i;
  logic        mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
  logic [31:0] mem_i_inst_o;
  logic [31:0] mem_d_addr_i, mem_d_data_wr_i;
  logic        mem_d_rd_i, mem_d_cacheable_i;
  logic [3:0]  mem_d_wr_i;
  logic [10:0] mem_d_req_tag_i, mem_d_resp_tag_o;
  logic        mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i;
  logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
  logic [31:0] mem_d_data_rd_o;
  logic [31:0] mem_addr_o, mem_data_wr_o, mem_data_rd_i;
  logic        mem_rd_o;
  logic [3:0]  mem_wr_o;
  logic        mem_accept_i, mem_ack_i, mem_error_i;

  logic        ack_hold, err_inj;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk_i = ~clk_i;

  tcm_port_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_i_rd_i(mem_i_rd_i), .mem_i_pc_i(mem_i_pc_i),
    .mem_i_flush_i(mem_i_flush_i), .mem_i_invalidate_i(mem_i_invalidate_i),
    .mem_i_accept_o(mem_i_accept_o), .mem_i_valid_o(mem_i_valid_o),
    .mem_i_error_o(mem_i_error_o), .mem_i_inst_o(mem_i_inst_o),
    .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i),
    .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i),
    .mem_d_cacheable_i(mem_d_cacheable_i), .mem_d_req_tag_i(mem_d_req_tag_i),
    .mem_d_invalidate_i(mem_d_invalidate_i), .mem_d_writeback_i(mem_d_writeback_i),
    .mem_d_flush_i(mem_d_flush_i), .mem_d_accept_o(mem_d_accept_o),
    .mem_d_ack_o(mem_d_ack_o), .mem_d_error_o(mem_d_error_o),
    .mem_d_data_rd_o(mem_d_data_rd_o), .mem_d_resp_tag_o(mem_d_resp_tag_o),
    .mem_addr_o(mem_addr_o), .mem_data_wr_o(mem_data_wr_o),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
    .mem_accept_i(mem_accept_i), .mem_ack_i(mem_ack_i),
    .mem_error_i(mem_error_i), .mem_data_rd_i(mem_data_rd_i)
  );

  // In-order responder: acks each taken request one or more cycles later.
  logic [31:0] pend_addr [4];
  logic [1:0]  pend_wr, pend_rd;
  logic [2:0]  pend_cnt;
  logic        dn_take;

  assign dn_take       = mem_accept_i && (mem_rd_o || (mem_wr_o != 4'b0));
  assign mem_ack_i     = (pend_cnt != 3'd0) && !ack_hold;
  assign mem_data_rd_i = mem_ack_i ? ~pend_addr[pend_rd] : 32'h0;
  assign mem_error_i   = mem_ack_i && err_inj;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_wr  <= 2'd0;
      pend_rd  <= 2'd0;
      pend_cnt <= 3'd0;
    end else begin
      if (dn_take) begin
        pend_addr[pend_wr] <= mem_addr_o;
        pend_wr            <= pend_wr + 2'd1;
      end
      if (mem_ack_i) pend_rd <= pend_rd + 2'd1;
      pend_cnt <= pend_cnt + {2'b0, dn_take} - {2'b0, mem_ack_i};
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    mem_i_rd_i = 0; mem_i_pc_i = 0; mem_i_flush_i = 0; mem_i_invalidate_i = 0;
    mem_d_addr_i = 0; mem_d_data_wr_i = 0; mem_d_rd_i = 0; mem_d_wr_i = 0;
    mem_d_cacheable_i = 0; mem_d_req_tag_i = 0;
    mem_d_invalidate_i = 0; mem_d_writeback_i = 0; mem_d_flush_i = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1; ack_hold = 0; err_inj = 0; mem_accept_i = 1;
    idle_inputs();
    cyc(); cyc();
    @(negedge clk_i);
    chk("rst_req_out", {mem_rd_o, mem_wr_o, mem_addr_o[0]}, 0);
    chk("rst_accepts", {mem_i_accept_o, mem_d_accept_o}, 0);
    chk("rst_resps", {mem_i_valid_o, mem_d_ack_o, mem_i_error_o, mem_d_error_o}, 0);
    cyc(); rst_i = 0;

    // 1: back-to-back fetches, latency 1
    mem_i_rd_i = 1; mem_i_pc_i = 32'h8000_0000;
    @(negedge clk_i);
    chk("t1_acc0", mem_i_accept_o, 1);
    chk("t1_addr0", mem_addr_o, 32'h8000_0000);
    cyc(); mem_i_pc_i = 32'h8000_0004;
    @(negedge clk_i);
    chk("t1_acc1", mem_i_accept_o, 1);
    chk("t1_noval", mem_i_valid_o, 0);
    cyc(); mem_i_rd_i = 0;
    @(negedge clk_i);
    chk("t1_val0", mem_i_valid_o, 1);
    chk("t1_inst0", mem_i_inst_o, 32'h7FFF_FFFF);
    chk("t1_dack", mem_d_ack_o, 0);
    cyc();
    @(negedge clk_i);
    chk("t1_val1", mem_i_valid_o, 1);
    chk("t1_inst1", mem_i_inst_o, 32'h7FFF_FFFB);
    cyc();
    @(negedge clk_i);
    chk("t1_pulse", mem_i_valid_o, 0);
    cyc();

    // 2: continuous contention alternates D,I,D,I
    mem_i_rd_i = 1; mem_i_pc_i = 32'h8000_0008;
    mem_d_rd_i = 1; mem_d_addr_i = 32'h8000_1000; mem_d_req_tag_i = 11'h05;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("t2_dacc", mem_d_accept_o, (k % 2 == 0) ? 1 : 0);
      chk("t2_iacc", mem_i_accept_o, (k % 2 == 1) ? 1 : 0);
      if (k == 2) begin
        chk("t2_dack", mem_d_ack_o, 1);
        chk("t2_dtag", mem_d_resp_tag_o, 11'h05);
        chk("t2_ddata", mem_d_data_rd_o, 32'h7FFF_EFFF);
      end
      cyc();
    end
    idle_inputs();
    repeat (4) cyc();

    // 3: downstream stalls a held load for 3 cycles
    mem_d_rd_i = 1; mem_d_addr_i = 32'h8000_1000; mem_d_req_tag_i = 11'h21;
    mem_accept_i = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("t3_noacc", mem_d_accept_o, 0);
      chk("t3_addr", mem_addr_o, 32'h8000_1000);
      chk("t3_rd", mem_rd_o, 1);
      cyc();
    end
    mem_accept_i = 1;
    @(negedge clk_i);
    chk("t3_acc", mem_d_accept_o, 1);
    cyc(); idle_inputs();
    cyc();
    @(negedge clk_i);
    chk("t3_ack", mem_d_ack_o, 1);
    chk("t3_tag", mem_d_resp_tag_o, 11'h21);
    repeat (2) cyc();

    // 4: fill with fetches, flush before acks
    ack_hold = 1;
    mem_i_rd_i = 1; mem_i_pc_i = 32'h8000_0100;
    @(negedge clk_i); chk("t4_acc0", mem_i_accept_o, 1);
    cyc(); mem_i_pc_i = 32'h8000_0104;
    @(negedge clk_i); chk("t4_acc1", mem_i_accept_o, 1);
    cyc(); mem_i_pc_i = 32'h8000_0108; mem_i_flush_i = 1;
    @(negedge clk_i);
    chk("t4_flush_acc", mem_i_accept_o, 0);
    chk("t4_full_rd", mem_rd_o, 0);
    cyc(); mem_i_flush_i = 0; mem_i_rd_i = 0; ack_hold = 0;
    @(negedge clk_i); chk("t4_kill_a", mem_i_valid_o, 0);
    cyc();
    @(negedge clk_i); chk("t4_kill_b", mem_i_valid_o, 0);
    cyc(); mem_i_rd_i = 1;
    @(negedge clk_i);
    chk("t4_kill_c", mem_i_valid_o, 0);
    chk("t4_acc2", mem_i_accept_o, 1);
    cyc(); mem_i_rd_i = 0;
    @(negedge clk_i); chk("t4_kill_d", mem_i_valid_o, 0);
    cyc();
    @(negedge clk_i);
    chk("t4_val", mem_i_valid_o, 1);
    chk("t4_inst", mem_i_inst_o, 32'h7FFF_FEF7);
    cyc();

    // 5: store then local cache op, acked in order
    mem_d_wr_i = 4'hF; mem_d_addr_i = 32'h8000_2000; mem_d_data_wr_i = 32'hDEAD_BEEF;
    mem_d_req_tag_i = 11'h12;
    @(negedge clk_i);
    chk("t5_st_acc", mem_d_accept_o, 1);
    chk("t5_st_wr", {mem_rd_o, mem_wr_o}, 5'h0F);
    chk("t5_st_data", mem_data_wr_o, 32'hDEAD_BEEF);
    cyc(); idle_inputs(); mem_d_flush_i = 1; mem_d_req_tag_i = 11'h13;
    @(negedge clk_i);
    chk("t5_op_acc", mem_d_accept_o, 1);
    chk("t5_op_nodn", {mem_rd_o, mem_wr_o}, 0);
    cyc(); idle_inputs();
    @(negedge clk_i);
    chk("t5_ack0", mem_d_ack_o, 1);
    chk("t5_tag0", mem_d_resp_tag_o, 11'h12);
    cyc();
    @(negedge clk_i);
    chk("t5_ack1", mem_d_ack_o, 1);
    chk("t5_tag1", mem_d_resp_tag_o, 11'h13);
    chk("t5_data1", {mem_d_error_o, mem_d_data_rd_o}, 0);
    cyc();
    @(negedge clk_i); chk("t5_pulse", mem_d_ack_o, 0);
    cyc();

    // 6: load error, then reset mid-transaction
    mem_d_rd_i = 1; mem_d_addr_i = 32'h8000_3000; mem_d_req_tag_i = 11'h2A; err_inj = 1;
    @(negedge clk_i); chk("t6_acc", mem_d_accept_o, 1);
    cyc(); idle_inputs();
    cyc(); err_inj = 0;
    @(negedge clk_i);
    chk("t6_ack", mem_d_ack_o, 1);
    chk("t6_err", mem_d_error_o, 1);
    cyc(); mem_d_rd_i = 1; mem_d_addr_i = 32'h8000_3004;
    @(negedge clk_i); chk("t6_acc2", mem_d_accept_o, 1);
    cyc(); rst_i = 1;
    @(negedge clk_i);
    chk("t6_rst_req", {mem_rd_o, mem_wr_o, mem_d_accept_o, mem_i_accept_o}, 0);
    chk("t6_rst_resp", {mem_d_ack_o, mem_i_valid_o, mem_d_error_o}, 0);
    cyc(); rst_i = 0; idle_inputs(); ack_hold = 1;
    mem_i_rd_i = 1; mem_i_pc_i = 32'h8000_0200;
    @(negedge clk_i); chk("t6_f0", mem_i_accept_o, 1);
    cyc(); mem_i_pc_i = 32'h8000_0204;
    @(negedge clk_i); chk("t6_f1", mem_i_accept_o, 1);
    cyc(); mem_i_pc_i = 32'h8000_0208;
    @(negedge clk_i); chk("t6_full", mem_i_accept_o, 0);
    cyc(); mem_i_rd_i = 0; ack_hold = 0;
    cyc();
    @(negedge clk_i);
    chk("t6_val0", mem_i_valid_o, 1);
    chk("t6_inst0", mem_i_inst_o, 32'h7FFF_FDFF);
    cyc();
    @(negedge clk_i);
    chk("t6_val1", mem_i_valid_o, 1);
    chk("t6_inst1", mem_i_inst_o, 32'h7FFF_FDFB);
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
